// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial line in, deframed byte and status strobes out.
// The receiver attaches through the slave modport; the line driver uses master.
interface uart_byte_rx_if;
    logic       rx;
    logic       uart_flag;
    logic [7:0] uart_data;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx,
        input  uart_flag,
        input  uart_data,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output uart_flag,
        output uart_data,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: oversampling 8N1 receiver, one strobe per good byte.
// Framing errors raise frame_err and never update uart_data.
module uart_byte_rx #(
    parameter int unsigned CLK_DIV = 5208,
    parameter int unsigned HALF    = CLK_DIV / 2
) (
    input  logic         sclk,
    input  logic         reset,
    uart_byte_rx_if.slave bus
);

    typedef enum logic {
        IDLE,
        RX
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_CNT = 16'(HALF);

    state_t      state;
    logic        s1, s2, s3;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0]  bit_idx;
    logic [3:0]  idx_nxt;
    logic        wrap;
    logic        sample;
    logic        fall;
    logic [7:0]  shift;
    logic [7:0]  data_q;
    logic        flag_q;
    logic        err_q;

    // Chain resets low so a line held low across reset cannot look like a start.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        fall    = s3 & ~s2;
        wrap    = (cnt == DIV_LAST);
        cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;
        idx_nxt = wrap ? bit_idx + 4'd1 : bit_idx;
        sample  = (cnt_nxt == HALF_CNT);
    end

    // Sampling fires on the edge at which cnt reaches HALF.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 4'd0;
            shift   <= 8'h00;
            data_q  <= 8'h00;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= RX;
                        cnt     <= 16'd0;
                        bit_idx <= 4'd0;
                    end
                end
                RX: begin
                    cnt     <= cnt_nxt;
                    bit_idx <= idx_nxt;
                    if (sample) begin
                        unique case (1'b1)
                            (bit_idx == 4'd0): begin
                                if (s2) begin
                                    state <= IDLE;
                                end
                            end
                            (bit_idx == 4'd9): begin
                                state <= IDLE;
                                if (s2) begin
                                    data_q <= shift;
                                    flag_q <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            default: begin
                                shift[3'(bit_idx - 4'd1)] <= s2;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.uart_flag = flag_q;
    assign bus.uart_data = data_q;
    assign bus.frame_err = err_q;
    assign bus.rx_busy   = (state == RX);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench driving bit-accurate 8N1 frames.
// Expected bytes queue on send and are matched as strobes appear.
module tb_uart_byte_rx;

    localparam int DIV  = 16;
    localparam int HALF = 8;

    logic sclk  = 1'b0;
    logic reset = 1'b1;

    uart_byte_rx_if u_if ();

    uart_byte_rx #(
        .CLK_DIV(DIV),
        .HALF   (HALF)
    ) dut (
        .sclk (sclk),
        .reset(reset),
        .bus  (u_if)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [8:0] exp_q[$];
    int         flag_cycs[$];
    logic [7:0] last_good = 8'h00;

    int   busy_start = -1;
    int   busy_end   = -1;
    int   busy_seen  = 0;
    int   err_seen   = 0;
    logic prev_flag  = 1'b0;
    logic prev_err   = 1'b0;
    logic prev_busy  = 1'b0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge sclk) begin
        logic [8:0] e;
        if (u_if.uart_flag || u_if.frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("rx_out", {u_if.frame_err, u_if.uart_data}, e);
            end
            if (u_if.uart_flag) flag_cycs.push_back(cyc);
            if (u_if.frame_err) err_seen++;
        end
        if (prev_flag) check("flag_width", u_if.uart_flag, 0);
        if (prev_err) check("err_width", u_if.frame_err, 0);
        if (u_if.rx_busy && !prev_busy) begin
            busy_start = cyc;
            busy_seen++;
        end
        if (!u_if.rx_busy && prev_busy) busy_end = cyc;
        prev_flag = u_if.uart_flag;
        prev_err  = u_if.frame_err;
        prev_busy = u_if.rx_busy;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        u_if.rx = v;
        wait_cycles(DIV);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit good);
        if (good) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(good);
    endtask

    initial begin
        int t0;
        int nf;
        int ne;
        int bs;
        logic [7:0] burst[6];
        burst = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04};

        u_if.rx = 1'b1;
        #1;
        check("rst_flag", u_if.uart_flag, 0);
        check("rst_err", u_if.frame_err, 0);
        check("rst_busy", u_if.rx_busy, 0);
        check("rst_data", u_if.uart_data, 8'h00);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(20);

        // single byte with latency and busy window
        flag_cycs.delete();
        t0 = cyc + 1;
        send_byte(8'h55, 1'b1);
        check("t1_nflag", flag_cycs.size(), 1);
        if (flag_cycs.size() > 0) check("t1_latency", flag_cycs[0] - t0, 154);
        check("t1_busy_start", busy_start - t0, 2);
        check("t1_busy_end", busy_end - t0, 154);
        check("t1_no_err", err_seen, 0);
        wait_cycles(20);

        // back-to-back burst
        flag_cycs.delete();
        foreach (burst[i]) send_byte(burst[i], 1'b1);
        check("t2_nflag", flag_cycs.size(), 6);
        for (int i = 1; i < flag_cycs.size(); i++)
            check("t2_spacing", flag_cycs[i] - flag_cycs[i-1], 160);
        wait_cycles(20);

        // framing error then recovery
        nf = flag_cycs.size();
        ne = err_seen;
        send_byte(8'hA5, 1'b0);
        check("t3_err_cnt", err_seen - ne, 1);
        check("t3_no_flag", flag_cycs.size() - nf, 0);
        check("t3_data_hold", u_if.uart_data, 8'h04);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_byte(8'h3C, 1'b1);
        check("t3_recover", flag_cycs.size() - nf, 1);
        wait_cycles(20);

        // short glitch is a false start
        nf = flag_cycs.size();
        t0 = cyc + 1;
        u_if.rx = 1'b0;
        wait_cycles(4);
        u_if.rx = 1'b1;
        wait_cycles(40);
        check("t4_busy_start", busy_start - t0, 2);
        check("t4_busy_end", busy_end - t0, 2 + HALF);
        check("t4_no_flag", flag_cycs.size() - nf, 0);
        send_byte(8'hFF, 1'b1);
        check("t4_ff_flag", flag_cycs.size() - nf, 1);
        wait_cycles(20);

        // reset during data bit 4 of 0x81
        nf = flag_cycs.size();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        u_if.rx = 1'b0;
        wait_cycles(8);
        reset = 1'b1;
        #1;
        check("t5_busy_rst", u_if.rx_busy, 0);
        wait_cycles(5);
        u_if.rx = 1'b1;
        reset = 1'b0;
        wait_cycles(3 * DIV);
        check("t5_no_flag", flag_cycs.size() - nf, 0);
        send_byte(8'h7E, 1'b1);
        check("t5_one_flag", flag_cycs.size() - nf, 1);
        wait_cycles(20);

        // line held low across reset release
        nf = flag_cycs.size();
        reset = 1'b1;
        u_if.rx = 1'b0;
        wait_cycles(5);
        reset = 1'b0;
        bs = busy_seen;
        wait_cycles(100);
        u_if.rx = 1'b1;
        wait_cycles(20);
        check("t6_no_busy", busy_seen - bs, 0);
        check("t6_no_flag", flag_cycs.size() - nf, 0);
        send_byte(8'h00, 1'b1);
        check("t6_zero_flag", flag_cycs.size() - nf, 1);
        wait_cycles(20);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-byte receiver for the host command link: oversamples the UART RX pin on `sclk`, deframes 8N1 characters and presents each good byte as `uart_data` qualified by a one-cycle `uart_flag` strobe. It sits directly upstream of the command decoder. That decoder consumes `uart_flag`/`uart_data` to build write/read triggers and SDRAM write-FIFO data. Framing errors are flagged and never strobed as data.

## Interface
- `CLK_DIV`, 5208: `sclk` cycles per bit (50 MHz / 9600 baud); legal range 8..65535.
- `HALF`, `CLK_DIV/2` (integer division): count value at which a bit is sampled (mid-bit).
- `sclk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `uart_flag`  out  1  one-cycle strobe: `uart_data` holds a new good byte.
- `uart_data`  out  8  last good byte; stable between strobes.
- `frame_err`  out  1  one-cycle strobe: the stop bit sampled low and the byte was discarded.
- `rx_busy`  out  1  high while a frame is being received (state RX).

## Operation
- Input conditioning: three-flop chain `s1`→`s2`→`s3` on `rx`. All three reset to 0. The falling edge condition is `s3==1 && s2==0`. Because the chain resets low, a line that is held low across reset release never starts a frame; the line must be seen high first.
- State machine: IDLE, RX.
  - IDLE: on the falling edge condition, go to RX with `cnt`←0 and `bit_idx`←0. No other condition leaves IDLE.
  - RX: `cnt` increments every cycle and wraps CLK_DIV-1→0. On the wrap, `bit_idx` increments. `bit_idx` 0 = start bit, 1..8 = data bits LSB first, 9 = stop bit. `cnt` is 16 bits and `bit_idx` is 4 bits; no other widths apply.
- Sampling: a bit is sampled on the edge where `cnt==HALF`, using `s2`.
  - `bit_idx==0`: if `s2==1` it is a false start. Return to IDLE with no strobe and no error.
  - `bit_idx` 1..8: shift `s2` into an internal shift register at bit position `bit_idx-1`.
  - `bit_idx==9`: return to IDLE at this same edge. If `s2==1`, `uart_data`←shift register and `uart_flag`←1 for one cycle. If `s2==0`, `frame_err`←1 for one cycle and `uart_data` is unchanged.
- Leaving RX at the stop-bit mid-point lets the receiver accept back-to-back frames. The next start edge is detected from IDLE.
- `uart_flag` and `frame_err` are mutually exclusive and registered. `rx_busy` is exactly `state==RX`.
- A falling edge seen while in RX is ignored. A resynchronisation happens only via IDLE.

## Timing
- Reset values: `uart_flag`=0, `frame_err`=0, `rx_busy`=0, `uart_data`=8'h00, state IDLE, `cnt`=0, `bit_idx`=0, shift register 0.
- Reset asserted mid-frame: all of the above apply immediately (asynchronous). The partial byte is lost and no strobe is produced. After release, reception resumes at the next start edge that follows a high line.
- Latency, counting T0 as the edge at which `s1` first captures `rx`=0:
  - State is RX at edge T0+2.
  - The stop sample is taken at edge T0+2+9·CLK_DIV+HALF.
  - `uart_flag` (or `frame_err`) is high for exactly the one cycle following that edge.
  - For the defaults this is 49478 cycles after T0.
- Throughput: one byte per 10 bit times with zero idle between frames. The bit rate tolerates ±4% clock/baud mismatch.
- The downstream stage must accept a strobe on any cycle. There is no back-pressure. The minimum spacing between strobes is 9·CLK_DIV+HALF cycles.

## Test plan
Simulate with `CLK_DIV`=16, `HALF`=8, and drive `rx` from a bit-accurate model with 16 cycles per bit.
- Reset, then send 0x55 once: `uart_flag` is high for 1 cycle exactly 154 cycles after T0, with `uart_data`=0x55; `frame_err` never rises; `rx_busy` is high from T0+2 through the stop sample.
- Send 0xAA, 0x55, 0x01, 0x02, 0x03, 0x04 back-to-back with no idle: six strobes with data in order and strobe spacing of 160 cycles.
- Send 0xA5 with the stop bit forced low: `frame_err` is high for 1 cycle, no `uart_flag`, and `uart_data` keeps its previous value. Then send 0x3C normally: it is received correctly.
- Drive a 4-cycle low glitch on an idle line: the receiver returns to IDLE at the start-bit mid-point with no strobes. Then send 0xFF: it is received.
- Assert `reset` during data bit 4 of 0x81, release it, then send 0x7E: no strobe for 0x81, and exactly one strobe with 0x7E.
- Hold `rx` low through reset release for 100 cycles, then drive it high: no `rx_busy` and no strobes. A subsequent 0x00 is received normally.
